// File: rtl/reaction_timer_ctrl_pkg.sv
// rtl/reaction_timer_ctrl_pkg.sv - shared states and constants for the reaction timer
package reaction_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RAND = 3'd1,
    ARMED     = 3'd2,
    DONE      = 3'd3,
    EARLY     = 3'd4,
    TIMEOUT   = 3'd5
  } state_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Fibonacci taps 16,14,13,11 expressed as zero-based bit indices
  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// rtl/reaction_timer_ctrl_if.sv - button/tick inputs and display/status outputs of the reaction timer
interface reaction_timer_ctrl_if;
  logic        clk1k;
  logic        start_btn;
  logic        react_btn;
  logic        led_go;
  logic [15:0] bcd;
  logic        result_valid;
  logic        early_flag;
  logic        timeout_flag;
  logic        busy;

  modport master (
    output clk1k, start_btn, react_btn,
    input  led_go, bcd, result_valid, early_flag, timeout_flag, busy
  );

  modport slave (
    input  clk1k, start_btn, react_btn,
    output led_go, bcd, result_valid, early_flag, timeout_flag, busy
  );
endinterface

// File: rtl/bcd_counter4.sv
// rtl/bcd_counter4.sv - 4-digit BCD up-counter saturating at 9999
module bcd_counter4
  import reaction_timer_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q,
  output logic        at_max
);

  logic [15:0] q_next;
  logic        carry;

  assign at_max = (q == BCD_MAX);

  // Ripple a carry from the units digit upward, wrapping each 9 to 0
  always_comb begin
    q_next = q;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (q[4*i +: 4] == 4'd9) begin
          q_next[4*i +: 4] = 4'd0;
        end else begin
          q_next[4*i +: 4] = q[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 16'h0000;
    end else if (clr) begin
      q <= 16'h0000;
    end else if (inc && !at_max) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// rtl/reaction_timer_ctrl.sv - reaction timer sequencer: random foreperiod, GO lamp, BCD ms count
module reaction_timer_ctrl #(
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 11,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic                 clk,
  input logic                 rst_n,
  reaction_timer_ctrl_if.slave io
);
  import reaction_timer_ctrl_pkg::*;

  localparam logic [15:0] MIN_D = 16'(MIN_DELAY_MS);

  logic [2:0]  sync_ms, sync_st, sync_rc;
  logic        ms_tick, start_p, react_p;
  logic [15:0] lfsr;
  logic [15:0] delay_cnt;
  logic [15:0] delay_load;
  state_t      state;
  logic        cnt_clr, cnt_inc, cnt_at_max;

  // Two synchroniser stages plus a history flop; the pulse itself is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ms <= 3'b000;
      sync_st <= 3'b000;
      sync_rc <= 3'b000;
      ms_tick <= 1'b0;
      start_p <= 1'b0;
      react_p <= 1'b0;
    end else begin
      sync_ms <= {sync_ms[1:0], io.clk1k};
      sync_st <= {sync_st[1:0], io.start_btn};
      sync_rc <= {sync_rc[1:0], io.react_btn};
      ms_tick <= sync_ms[1] & ~sync_ms[2];
      start_p <= sync_st[1] & ~sync_st[2];
      react_p <= sync_rc[1] & ~sync_rc[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B] ^ lfsr[LFSR_TAP_C] ^ lfsr[LFSR_TAP_D]};
    end
  end

  assign delay_load = MIN_D + 16'(lfsr[RAND_BITS-1:0]);

  // A react in the same clk as a tick wins, so the tick is dropped from the count
  assign cnt_inc = (state == ARMED) && ms_tick && !react_p;
  assign cnt_clr = (start_p && (state == IDLE || state == DONE || state == EARLY || state == TIMEOUT))
                || ((state == WAIT_RAND) && ms_tick && !react_p && (delay_cnt == 16'd1));

  bcd_counter4 u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .q      (io.bcd),
    .at_max (cnt_at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      delay_cnt       <= 16'd0;
      io.led_go       <= 1'b0;
      io.result_valid <= 1'b0;
      io.early_flag   <= 1'b0;
      io.timeout_flag <= 1'b0;
      io.busy         <= 1'b0;
    end else begin
      io.result_valid <= 1'b0;
      case (state)
        WAIT_RAND: begin
          if (react_p) begin
            state         <= EARLY;
            io.busy       <= 1'b0;
            io.early_flag <= 1'b1;
          end else if (ms_tick) begin
            if (delay_cnt == 16'd1) begin
              state     <= ARMED;
              io.led_go <= 1'b1;
            end else begin
              delay_cnt <= delay_cnt - 16'd1;
            end
          end
        end
        ARMED: begin
          if (react_p) begin
            state           <= DONE;
            io.led_go       <= 1'b0;
            io.busy         <= 1'b0;
            io.result_valid <= 1'b1;
          end else if (ms_tick && cnt_at_max) begin
            state           <= TIMEOUT;
            io.led_go       <= 1'b0;
            io.busy         <= 1'b0;
            io.timeout_flag <= 1'b1;
          end
        end
        default: begin
          // IDLE, DONE, EARLY, TIMEOUT all restart on start and ignore react
          if (start_p) begin
            state           <= WAIT_RAND;
            delay_cnt       <= delay_load;
            io.busy         <= 1'b1;
            io.early_flag   <= 1'b0;
            io.timeout_flag <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb/tb_reaction_timer_ctrl.sv - randomized self-checking bench for reaction_timer_ctrl
module tb_reaction_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reaction_timer_ctrl_if io();

  reaction_timer_ctrl #(
    .MIN_DELAY_MS (5),
    .RAND_BITS    (2),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  int checks = 0;
  int failures = 0;
  int rv_cnt = 0;
  int led_cnt = 0;

  always @(negedge clk) begin
    if (io.result_valid === 1'b1) rv_cnt++;
    if (io.led_go === 1'b1) led_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: elapsed ms as decimal digits, capped at 9999
  function automatic logic [15:0] to_bcd(input int n);
    int m;
    m = (n > 9999) ? 9999 : n;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input int half, input bit with_react);
    io.clk1k = 1'b1;
    if (with_react) io.react_btn = 1'b1;
    wait_clk(half);
    io.clk1k = 1'b0;
    wait_clk(half);
    io.react_btn = 1'b0;
  endtask

  task automatic press(input bit st, input bit rc);
    io.start_btn = st;
    io.react_btn = rc;
    wait_clk(6);
    io.start_btn = 1'b0;
    io.react_btn = 1'b0;
    wait_clk(6);
  endtask

  task automatic arm(output int n);
    n = 0;
    while (io.led_go !== 1'b1 && n < 20) begin
      tick(10, 1'b0);
      n++;
    end
  endtask

  initial begin
    int n, k, j, rv0, led0;
    io.clk1k = 1'b0;
    io.start_btn = 1'b0;
    io.react_btn = 1'b0;

    repeat (30) begin
      io.clk1k = 1'($urandom);
      io.start_btn = 1'($urandom);
      io.react_btn = 1'($urandom);
      wait_clk(1);
    end
    chk("rst_led", io.led_go, 0);
    chk("rst_bcd", io.bcd, 16'h0000);
    chk("rst_rv", io.result_valid, 0);
    chk("rst_early", io.early_flag, 0);
    chk("rst_timeout", io.timeout_flag, 0);
    chk("rst_busy", io.busy, 0);
    io.clk1k = 1'b0;
    io.start_btn = 1'b0;
    io.react_btn = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(30);
    chk("idle_busy", io.busy, 0);
    chk("idle_led", io.led_go, 0);

    for (int r = 0; r < 4; r++) begin
      k = (r == 0) ? 123 : int'($urandom_range(0, 120));
      rv0 = rv_cnt;
      press(1'b1, 1'b0);
      chk("start_busy", io.busy, 1);
      arm(n);
      chk("arm_range", (n >= 5 && n <= 8), 1);
      repeat (k) tick(10, 1'b0);
      chk("armed_bcd", io.bcd, to_bcd(k));
      press(1'b0, 1'b1);
      chk("done_bcd", io.bcd, to_bcd(k));
      chk("done_rv_once", rv_cnt - rv0, 1);
      chk("done_led", io.led_go, 0);
      chk("done_busy", io.busy, 0);
    end

    for (int r = 0; r < 3; r++) begin
      led0 = led_cnt;
      press(1'b1, 1'b0);
      j = int'($urandom_range(0, 4));
      repeat (j) tick(10, 1'b0);
      press(1'b0, 1'b1);
      chk("early_flag", io.early_flag, 1);
      chk("early_bcd", io.bcd, 16'h0000);
      chk("early_no_led", led_cnt - led0, 0);
      chk("early_busy", io.busy, 0);
      press(1'b1, 1'b0);
      chk("restart_flag", io.early_flag, 0);
      chk("restart_busy", io.busy, 1);
      press(1'b0, 1'b1);
    end

    press(1'b1, 1'b0);
    arm(n);
    repeat (41) tick(10, 1'b0);
    rv0 = rv_cnt;
    tick(10, 1'b1);
    chk("coinc_bcd", io.bcd, 16'h0041);
    chk("coinc_rv", rv_cnt - rv0, 1);
    chk("coinc_led", io.led_go, 0);
    press(1'b1, 1'b1);
    chk("both_busy", io.busy, 1);
    chk("both_early", io.early_flag, 0);
    chk("both_bcd", io.bcd, 16'h0000);
    wait_clk(20);
    chk("held_early", io.early_flag, 0);

    arm(n);
    chk("to_arm", io.led_go, 1);
    repeat (9999) tick(2, 1'b0);
    chk("to_bcd_max", io.bcd, to_bcd(9999));
    chk("to_not_yet", io.timeout_flag, 0);
    chk("to_led_on", io.led_go, 1);
    tick(2, 1'b0);
    chk("to_flag", io.timeout_flag, 1);
    chk("to_hold", io.bcd, 16'h9999);
    chk("to_led_off", io.led_go, 0);
    chk("to_busy", io.busy, 0);
    tick(2, 1'b0);
    chk("to_nowrap", io.bcd, 16'h9999);

    press(1'b1, 1'b0);
    chk("to_restart", io.timeout_flag, 0);
    arm(n);
    repeat (200) tick(10, 1'b0);
    chk("mid_bcd", io.bcd, to_bcd(200));
    rv0 = rv_cnt;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", io.led_go, 0);
    chk("arst_busy", io.busy, 0);
    chk("arst_bcd", io.bcd, 16'h0000);
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(10);
    chk("arst_no_rv", rv_cnt - rv0, 0);
    press(1'b0, 1'b1);
    chk("arst_idle_busy", io.busy, 0);
    chk("arst_idle_early", io.early_flag, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
